// File: rtl/dpbram_pkg.sv
// dpbram_pkg: shared constants and helpers for the dual-port block RAM
package dpbram_pkg;
    localparam int WRITE_FIRST = 0;
    localparam int READ_FIRST  = 1;
    localparam int NO_CHANGE   = 2;
    localparam int COLL_CNT_W  = 16;

    function automatic int nlane(input int data, input int lane);
        return data / lane;
    endfunction
endpackage

// File: rtl/dpbram_rd_pipe.sv
// dpbram_rd_pipe: read data/valid delay line; stage 0 is the BRAM output register
module dpbram_rd_pipe #(
    parameter int DATA   = 72,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    input  logic [DATA-1:0] in_data,
    output logic            out_vld,
    output logic [DATA-1:0] out_data
);
    logic [DATA-1:0]   dat [RD_LAT];
    logic [RD_LAT-1:0] vld;

    // a stage only loads when the word arriving at it is valid, so the output holds between results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < RD_LAT; k++) dat[k] <= '0;
        end else begin
            vld[0] <= in_vld;
            if (in_vld) dat[0] <= in_data;
            for (int k = 1; k < RD_LAT; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) dat[k] <= dat[k-1];
            end
        end
    end

    assign out_vld  = vld[RD_LAT-1];
    assign out_data = dat[RD_LAT-1];
endmodule

// File: rtl/dual_port_bram_pipe.sv
// dual_port_bram_pipe: true dual-port BRAM with lane enables, read pipeline and collision monitor
module dual_port_bram_pipe
    import dpbram_pkg::*;
#(
    parameter int DATA    = 72,
    parameter int ADDR    = 10,
    parameter int LANE    = 8,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = WRITE_FIRST,
    localparam int NLANE  = nlane(DATA, LANE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_en,
    input  logic                  a_wr,
    input  logic [NLANE-1:0]      a_be,
    input  logic [ADDR-1:0]       a_addr,
    input  logic [DATA-1:0]       a_din,
    output logic [DATA-1:0]       a_dout,
    output logic                  a_vld,
    input  logic                  b_en,
    input  logic                  b_wr,
    input  logic [NLANE-1:0]      b_be,
    input  logic [ADDR-1:0]       b_addr,
    input  logic [DATA-1:0]       b_din,
    output logic [DATA-1:0]       b_dout,
    output logic                  b_vld,
    output logic                  coll,
    output logic [COLL_CNT_W-1:0] coll_cnt
);
    if (DATA % LANE != 0 || RD_LAT < 1 || RD_LAT > 3 ||
        (WR_MODE != WRITE_FIRST && WR_MODE != READ_FIRST && WR_MODE != NO_CHANGE)) begin : g_bad_param
        $error("dual_port_bram_pipe: illegal DATA/LANE, RD_LAT or WR_MODE");
    end

    localparam bit MERGE_WR = WR_MODE == WRITE_FIRST;
    localparam bit HOLD_WR  = WR_MODE == NO_CHANGE;

    logic [DATA-1:0] mem [2**ADDR];
    logic [DATA-1:0] a_mask, b_mask, a_old, b_old, a_rd, b_rd;
    logic            a_hit, b_hit, a_iss, b_iss;

    always_comb begin
        a_mask = '0;
        b_mask = '0;
        for (int i = 0; i < NLANE; i++) begin
            a_mask[i*LANE +: LANE] = {LANE{a_be[i]}};
            b_mask[i*LANE +: LANE] = {LANE{b_be[i]}};
        end
    end

    // a write with no lane enabled is treated exactly like a read
    assign a_hit = a_en && a_wr && |a_be;
    assign b_hit = b_en && b_wr && |b_be;
    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];
    assign a_rd  = (MERGE_WR && a_hit) ? (a_old & ~a_mask) | (a_din & a_mask) : a_old;
    assign b_rd  = (MERGE_WR && b_hit) ? (b_old & ~b_mask) | (b_din & b_mask) : b_old;
    assign a_iss = a_en && !(HOLD_WR && a_hit);
    assign b_iss = b_en && !(HOLD_WR && b_hit);

    // port A is applied last so it owns any lane both ports write
    always_ff @(posedge clk) begin
        for (int i = 0; i < NLANE; i++) begin
            if (b_hit && b_be[i]) mem[b_addr][i*LANE +: LANE] <= b_din[i*LANE +: LANE];
            if (a_hit && a_be[i]) mem[a_addr][i*LANE +: LANE] <= a_din[i*LANE +: LANE];
        end
    end

    dpbram_rd_pipe #(.DATA(DATA), .RD_LAT(RD_LAT)) u_a_pipe (
        .clk(clk), .rst_n(rst_n), .in_vld(a_iss), .in_data(a_rd), .out_vld(a_vld), .out_data(a_dout)
    );

    dpbram_rd_pipe #(.DATA(DATA), .RD_LAT(RD_LAT)) u_b_pipe (
        .clk(clk), .rst_n(rst_n), .in_vld(b_iss), .in_data(b_rd), .out_vld(b_vld), .out_data(b_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= a_hit && b_hit && a_addr == b_addr && |(a_be & b_be);
            if (coll && coll_cnt != '1) coll_cnt <= coll_cnt + 1'b1;
        end
    end
endmodule

// File: doc/dual_port_bram_pipe.md
# dual_port_bram_pipe

True dual-port block RAM with per-lane byte enables, a configurable read pipeline, a selectable write-collision read mode and collision monitoring. It is the drop-in successor to the plain dual-port BRAM used for on-chip operand and result buffers. Each port runs at one access per cycle, and a valid strobe accompanies every returned word. It also reports same-address write conflicts between the two ports.

## Interface
- DATA, 72: word width in bits; must be a multiple of LANE.
- ADDR, 10: address width; depth is 2**ADDR words.
- LANE, 8: bits per byte-enable lane; NLANE = DATA/LANE.
- RD_LAT, 1: read latency in cycles, legal values 1..3.
- WR_MODE, 0: same-port read-during-write behaviour; 0 = write-first, 1 = read-first, 2 = no-change.

Ports (x is a or b; port B is identical to port A):
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- x_en  in  1  access enable; when low, the port does nothing.
- x_wr  in  1  write request; only meaningful with x_en high.
- x_be  in  NLANE  lane write enables; only meaningful when x_wr is high.
- x_addr  in  ADDR  word address.
- x_din  in  DATA  write data.
- x_dout  out  DATA  read data.
- x_vld  out  1  x_dout carries the result of an access issued RD_LAT cycles earlier.
- coll  out  1  one-cycle pulse on a same-address, overlapping-lane dual write.
- coll_cnt  out  16  saturating count of collisions.

## Operation
- Access: x_en=1 at a clock edge. Idle: x_en=0. An idle port leaves memory untouched, holds x_dout, and drives x_vld=0 for that slot.
- Read (x_wr=0): returns mem[x_addr].
- Write (x_wr=1): writes lane i of mem[x_addr] only where x_be[i]=1. Lanes with x_be[i]=0 keep their old contents.
  - x_wr=1 with x_be all zero behaves as a read.
- Same-port returned data on a write, by WR_MODE:
  - write-first: the merged word (new lanes where be=1, old lanes elsewhere); x_vld=1.
  - read-first: the pre-write word; x_vld=1.
  - no-change: x_dout holds its previous value; x_vld=0 for that slot.
- Cross-port read of an address the other port writes in the same cycle: returns the pre-write word in all modes.
- Dual write to the same address in the same cycle:
  - Lanes enabled on both ports take port A's data.
  - Lanes enabled on one port only take that port's data.
  - If any lane overlaps, coll pulses high for one cycle, 1 cycle after the edge.
  - coll_cnt increments on each collision and saturates at 0xFFFF.
- Same address, non-overlapping lanes: no collision.
- Reset (rst_n low, asynchronous):
  - x_dout=0, x_vld=0, every pipeline stage cleared, coll=0, coll_cnt=0.
  - Memory contents are not reset.
  - Reads in flight when reset asserts are discarded; no x_vld is produced for them after release.
- Reset release: the first edge with rst_n high may carry an access.
- Elaboration fails on: DATA % LANE != 0, RD_LAT outside 1..3, or WR_MODE > 2.

## Timing
- Issue: x_en, x_wr, x_be, x_addr and x_din are sampled at edge N.
- Write visibility: memory is updated at edge N. A read issued at edge N+1 sees the new data.
- Read latency: x_dout/x_vld are valid after edge N+RD_LAT-1 and held until the next edge.
  - Stage 1 is the BRAM output register.
  - Stages 2..RD_LAT are plain registers and must remain inferable as BRAM output pipelining.
- Throughput: one access per port per cycle, back-to-back, with no bubbles.
- x_vld is a pure delay of the issue strobe (x_en, gated off in no-change writes). There is no backpressure.
- Pipeline registers shift only when their valid bit is set; x_dout holds otherwise.
- coll is asserted in the cycle after edge N and is independent of RD_LAT. coll_cnt updates at edge N+1.

## Structure
- Package dpbram_pkg:
  - WR_MODE constants WRITE_FIRST=0, READ_FIRST=1, NO_CHANGE=2.
  - COLL_CNT_W=16.
  - Function nlane(DATA, LANE).
- Top level owns the shared memory array, lane-masked writes, collision detect and coll_cnt.
- Sub-module dpbram_rd_pipe (parameters DATA, RD_LAT): data/valid delay line with async reset, instantiated once per port.

## Test plan
- Basic read-back, RD_LAT=1/2/3: write 0x..AA to addr 5 on A, read addr 5 on B next cycle -> b_dout=0x..AA with b_vld exactly RD_LAT cycles after issue.
- Byte enables: preload 0x..FFFF at addr 3; A writes 0x..1234 with be=0b...01 -> later read returns 0x..FF34.
- WR_MODE sweep: mem[7]=0x11 (be all ones):
  - write 0x22 to addr 7 on the same port -> write-first returns 0x22, read-first returns 0x11.
  - no-change: a_vld=0 and a_dout holds its prior value.
- Collision:
  - A and B write addr 9 together, be all ones, A=0x1, B=0x2 -> mem[9]=0x1, coll pulses once, coll_cnt=1.
  - Same addr with disjoint be -> merged word, no coll.
  - 70000 collisions -> coll_cnt=0xFFFF.
- Reset mid-operation, RD_LAT=3: issue reads on 3 consecutive cycles, assert rst_n low between them:
  - outputs go to 0 immediately; no x_vld appears after release.
  - prior memory data is still readable afterwards.
